// File: rtl/spi_arb_pkg.sv
// Shared types, idle bus levels and counter sizing for the SPI flash arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } arb_state_e;

    // Levels driven onto the flash pads whenever no owner is connected
    localparam logic SPI_IDLE_CS   = 1'b1;
    localparam logic SPI_IDLE_SCK  = 1'b0;
    localparam logic SPI_IDLE_MOSI = 1'b0;

    // Bits needed to hold values 0..n; never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n == 0) ? 32'd1 : 32'($clog2(n + 1));
    endfunction

    localparam int unsigned GUARD_CYCLES_DEF   = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 0;
    localparam int unsigned GUARD_CNT_W_DEF    = cnt_w(GUARD_CYCLES_DEF);
    localparam int unsigned HOLD_CNT_W_DEF     = cnt_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/spi_arb_counter.sv
// Loadable down-counter that saturates at zero; done_c is high while at zero.
module spi_arb_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done_c
);

    logic [W-1:0] count;

    // Load wins over count; counting stops at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-requester arbiter for the shared SPI configuration flash: round-robin
// grant, chip-select-high guard gap between owners, optional hold timeout.
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES   = GUARD_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    input  logic cs0,
    input  logic sck0,
    input  logic mosi0,
    input  logic cs1,
    input  logic sck1,
    input  logic mosi1,
    output logic miso0,
    output logic miso1,
    input  logic spi_miso,
    output logic spi_cs,
    output logic spi_sck,
    output logic spi_mosi,
    output logic owner,
    output logic busy,
    output logic timeout_evt
);

    localparam int unsigned GUARD_W = cnt_w(GUARD_CYCLES);
    localparam int unsigned HOLD_W  = cnt_w(TIMEOUT_CYCLES);

    arb_state_e state, state_d;
    logic owner_d, gnt0_d, gnt1_d, busy_d, timeout_d;
    logic cs_d, sck_d, mosi_d;
    logic blocked0, blocked1, blocked0_d, blocked1_d;
    logic guard_load, hold_load, guard_done_c, hold_done_c;
    logic own_req, oth_req, elig0, elig1, hold_expired;

    assign own_req      = owner ? req1 : req0;
    assign oth_req      = owner ? req0 : req1;
    assign elig0        = req0 & ~blocked0;
    assign elig1        = req1 & ~blocked1;
    assign hold_expired = (TIMEOUT_CYCLES != 0) && hold_done_c && oth_req;

    // Guard gap: loaded on release so GUARD lasts exactly GUARD_CYCLES cycles
    spi_arb_counter #(.W(GUARD_W)) u_guard_cnt (
        .clk      (clk_48mhz),
        .reset    (reset),
        .load     (guard_load),
        .load_val (GUARD_W'(GUARD_CYCLES - 1)),
        .en       (state == GUARD),
        .done_c   (guard_done_c)
    );

    // Hold timer: reaches zero after TIMEOUT_CYCLES cycles of contention
    spi_arb_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk      (clk_48mhz),
        .reset    (reset),
        .load     (hold_load),
        .load_val (HOLD_W'(TIMEOUT_CYCLES)),
        .en       ((state == GRANT) && oth_req),
        .done_c   (hold_done_c)
    );

    // Next state, arbitration and next values of every registered output
    always_comb begin
        state_d    = state;
        owner_d    = owner;
        timeout_d  = 1'b0;
        cs_d       = SPI_IDLE_CS;
        sck_d      = SPI_IDLE_SCK;
        mosi_d     = SPI_IDLE_MOSI;
        blocked0_d = blocked0 & req0;
        blocked1_d = blocked1 & req1;
        guard_load = 1'b0;
        hold_load  = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    state_d   = GRANT;
                    owner_d   = (elig0 && elig1) ? ~owner : elig1;
                    hold_load = 1'b1;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    state_d    = GUARD;
                    guard_load = 1'b1;
                end else if (hold_expired) begin
                    state_d    = GUARD;
                    guard_load = 1'b1;
                    timeout_d  = 1'b1;
                    if (owner) blocked1_d = 1'b1;
                    else       blocked0_d = 1'b1;
                end else begin
                    cs_d   = owner ? cs1   : cs0;
                    sck_d  = owner ? sck1  : sck0;
                    mosi_d = owner ? mosi1 : mosi0;
                end
            end
            GUARD: begin
                if (guard_done_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        gnt0_d = (state_d == GRANT) && !owner_d;
        gnt1_d = (state_d == GRANT) &&  owner_d;
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            busy        <= 1'b0;
            timeout_evt <= 1'b0;
            spi_cs      <= SPI_IDLE_CS;
            spi_sck     <= SPI_IDLE_SCK;
            spi_mosi    <= SPI_IDLE_MOSI;
            blocked0    <= 1'b0;
            blocked1    <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            gnt0        <= gnt0_d;
            gnt1        <= gnt1_d;
            busy        <= busy_d;
            timeout_evt <= timeout_d;
            spi_cs      <= cs_d;
            spi_sck     <= sck_d;
            spi_mosi    <= mosi_d;
            blocked0    <= blocked0_d;
            blocked1    <= blocked1_d;
        end
    end

    // MISO returned only to the registered grant holder
    assign miso0 = gnt0 & spi_miso;
    assign miso1 = gnt1 & spi_miso;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: directed timing checks plus randomized traffic
// compared every cycle against a cycle-level behavioural model.
module tb_spi_flash_arbiter;

    localparam int G = 4;
    localparam int T = 16;

    logic clk_48mhz = 1'b0;
    logic reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic cs0 = 1'b1, sck0 = 1'b0, mosi0 = 1'b0;
    logic cs1 = 1'b1, sck1 = 1'b0, mosi1 = 1'b0;
    logic spi_miso = 1'b0;
    logic gnt0, gnt1, miso0, miso1, spi_cs, spi_sck, spi_mosi, owner, busy, timeout_evt;

    int n_checks = 0;
    int n_fail   = 0;

    spi_flash_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clk_48mhz   (clk_48mhz),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .cs0         (cs0),
        .sck0        (sck0),
        .mosi0       (mosi0),
        .cs1         (cs1),
        .sck1        (sck1),
        .mosi1       (mosi1),
        .miso0       (miso0),
        .miso1       (miso1),
        .spi_miso    (spi_miso),
        .spi_cs      (spi_cs),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .owner       (owner),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_48mhz);
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid = 1'b0;
    bit m_granted, m_owner, m_to, m_cs, m_sck, m_mosi, m_blk0, m_blk1;
    int m_guard, m_hold;
    bit s_rst, r0, r1, c0, k0, o0, c1, k1, o1, nb0, nb1, own_r, oth_r, e0, e1, eg0, eg1;
    logic [9:0] m_exp, m_got;

    initial begin : model
        forever begin
            @(posedge clk_48mhz);
            s_rst = reset; r0 = req0; r1 = req1;
            c0 = cs0; k0 = sck0; o0 = mosi0; c1 = cs1; k1 = sck1; o1 = mosi1;
            if (s_rst) begin
                m_valid = 1'b1; m_granted = 1'b0; m_owner = 1'b1; m_guard = 0; m_hold = 0;
                m_blk0 = 1'b0; m_blk1 = 1'b0; m_to = 1'b0;
                m_cs = 1'b1; m_sck = 1'b0; m_mosi = 1'b0;
            end else if (m_valid) begin
                nb0 = m_blk0 && r0;
                nb1 = m_blk1 && r1;
                m_to = 1'b0; m_cs = 1'b1; m_sck = 1'b0; m_mosi = 1'b0;
                if (m_granted) begin
                    own_r = m_owner ? r1 : r0;
                    oth_r = m_owner ? r0 : r1;
                    if (!own_r) begin
                        m_granted = 1'b0; m_guard = G;
                    end else if (T != 0 && m_hold >= T && oth_r) begin
                        m_granted = 1'b0; m_guard = G; m_to = 1'b1;
                        if (m_owner) nb1 = 1'b1; else nb0 = 1'b1;
                    end else begin
                        m_cs   = m_owner ? c1 : c0;
                        m_sck  = m_owner ? k1 : k0;
                        m_mosi = m_owner ? o1 : o0;
                        if (oth_r && m_hold < T) m_hold++;
                    end
                end else if (m_guard > 0) begin
                    m_guard--;
                end else begin
                    e0 = r0 && !m_blk0;
                    e1 = r1 && !m_blk1;
                    if (e0 || e1) begin
                        m_owner   = (e0 && e1) ? !m_owner : e1;
                        m_granted = 1'b1;
                        m_hold    = 0;
                    end
                end
                m_blk0 = nb0; m_blk1 = nb1;
            end
            #1;
            if (m_valid) begin
                eg0 = m_granted && !m_owner;
                eg1 = m_granted && m_owner;
                m_exp = {eg0, eg1, m_owner, (m_granted || m_guard > 0), m_to,
                         m_cs, m_sck, m_mosi, eg0 & spi_miso, eg1 & spi_miso};
                m_got = {gnt0, gnt1, owner, busy, timeout_evt,
                         spi_cs, spi_sck, spi_mosi, miso0, miso1};
                chk("model_cycle", 32'(m_got), 32'(m_exp));
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        cs0 = 1'b1; cs1 = 1'b1; sck0 = 1'b0; sck1 = 1'b0;
        tick(3);
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick(1);
            n++;
        end
        chk("wait_idle", 32'(busy), 0);
    endtask

    initial begin : stim
        int lat, lows, hits;
        @(negedge clk_48mhz);
        do_reset();
        chk("rst_spi_cs", 32'(spi_cs), 1);
        chk("rst_spi_sck", 32'(spi_sck), 0);
        chk("rst_gnt", 32'({gnt0, gnt1}), 0);
        chk("rst_owner", 32'(owner), 1);
        chk("rst_busy", 32'(busy), 0);

        // single requester
        tick(1);
        chk("single_pre_gnt0", 32'(gnt0), 0);
        req0 = 1'b1;
        tick(1);
        chk("single_gnt", 32'({gnt0, gnt1}), 2);
        cs0 = 1'b0; spi_miso = 1'b1;
        #1;
        chk("single_miso0", 32'(miso0), 1);
        chk("single_miso1", 32'(miso1), 0);
        tick(1);
        chk("single_cs_track", 32'(spi_cs), 0);
        for (int i = 0; i < 6; i++) begin
            sck0 = ~sck0;
            lat = int'(sck0);
            tick(1);
            chk("single_sck_track", 32'(spi_sck), 32'(lat));
        end
        req0 = 1'b0; cs0 = 1'b1; sck0 = 1'b0; spi_miso = 1'b0;
        wait_idle();

        // tie from reset, guard gap with a misbehaving owner keeping cs0 low
        do_reset();
        req0 = 1'b1; req1 = 1'b1; cs0 = 1'b0; cs1 = 1'b0;
        tick(1);
        chk("tie_gnt0_first", 32'({gnt0, gnt1}), 2);
        tick(3);
        chk("tie_cs_low", 32'(spi_cs), 0);
        req0 = 1'b0;
        lat = 99; lows = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (spi_cs !== 1'b1) lows++;
            if (gnt1) begin
                lat = i;
                break;
            end
        end
        chk("gap_gnt1_latency", 32'(lat), 6);
        chk("gap_spi_cs_low_cycles", 32'(lows), 0);
        tick(2);
        chk("tie_gnt1_cs", 32'(spi_cs), 0);
        req1 = 1'b0; cs0 = 1'b1; cs1 = 1'b1;
        wait_idle();
        req0 = 1'b1; req1 = 1'b1;
        tick(1);
        chk("rr_tie_gnt0", 32'({gnt0, gnt1}), 2);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // hold timeout
        req0 = 1'b1; cs0 = 1'b0;
        tick(1);
        chk("to_gnt0", 32'(gnt0), 1);
        tick(2);
        req1 = 1'b1;
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (timeout_evt) begin
                lat = i;
                break;
            end
        end
        chk("to_latency", 32'(lat), 17);
        chk("to_gnt0_fall", 32'(gnt0), 0);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (i == 1) chk("to_pulse_width", 32'(timeout_evt), 0);
            if (gnt1) begin
                lat = i;
                break;
            end
        end
        chk("to_gnt1_after_guard", 32'(lat), 5);
        tick(4);
        req1 = 1'b0;
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (gnt0) hits++;
        end
        chk("blocked_no_regrant", 32'(hits), 0);
        req0 = 1'b0;
        tick(1);
        req0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (gnt0) break;
        end
        chk("unblock_regrant", 32'(gnt0), 1);
        req0 = 1'b0; cs0 = 1'b1;
        wait_idle();

        // reset in the middle of a transaction
        req1 = 1'b1; cs1 = 1'b0;
        tick(3);
        chk("mr_pre", 32'({gnt1, spi_cs}), 2);
        reset = 1'b1;
        tick(1);
        chk("mr_spi_cs", 32'(spi_cs), 1);
        chk("mr_gnt1", 32'(gnt1), 0);
        chk("mr_owner", 32'(owner), 1);
        chk("mr_busy", 32'(busy), 0);
        reset = 1'b0; req1 = 1'b0; cs1 = 1'b1;
        tick(2);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            if ($urandom_range(0, 15) == 0) req0 = ~req0;
            if ($urandom_range(0, 15) == 0) req1 = ~req1;
            cs0 = 1'($urandom_range(0, 1)); sck0 = 1'($urandom_range(0, 1));
            mosi0 = 1'($urandom_range(0, 1));
            cs1 = 1'($urandom_range(0, 1)); sck1 = 1'($urandom_range(0, 1));
            mosi1 = 1'($urandom_range(0, 1));
            spi_miso = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 599) == 0);
        end
        reset = 1'b0;
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
